// File: rtl/ucsbece154b_bp_perfmon_pkg.sv
// Shared definitions for the branch-prediction performance monitor:
// counter indices, per-cycle increment bundle and the saturating adder.
package ucsbece154b_perfmon_pkg;

    localparam int PERF_CYCLES      = 0;
    localparam int PERF_JMP_TOTAL   = 1;
    localparam int PERF_JMP_CORRECT = 2;
    localparam int PERF_BR_TOTAL    = 3;
    localparam int PERF_BR_CORRECT  = 4;
    localparam int PERF_NUM_CNT     = 5;
    localparam int PERF_IDX_W       = 3;
    localparam int PERF_SHADOW_BIT  = 3;
    localparam int PERF_ADDR_W      = PERF_SHADOW_BIT + 1;

    // Wide enough for any supported CNT_WIDTH (up to 63) plus the carry bit.
    localparam int PERF_WIDE_W = 64;
    typedef logic [PERF_WIDE_W-1:0] perf_wide_t;

    typedef struct packed {
        logic [1:0] jmp_total;
        logic [1:0] jmp_correct;
        logic [1:0] br_total;
        logic [1:0] br_correct;
    } perf_inc_t;

    function automatic perf_wide_t perf_sat_add(input perf_wide_t   val,
                                                input logic [1:0]   inc,
                                                input int unsigned  width);
        perf_wide_t max_v;
        perf_wide_t sum;
        max_v = (perf_wide_t'(1) << width) - perf_wide_t'(1);
        sum   = val + perf_wide_t'(inc);
        return (sum > max_v) ? max_v : sum;
    endfunction

endpackage

// File: rtl/ucsbece154b_bp_perfmon_if.sv
// Counter read port: one request per cycle, response exactly one cycle later.
interface ucsbece154b_bp_perfmon_if
    import ucsbece154b_perfmon_pkg::*;
#(
    parameter int CNT_WIDTH = 32
);
    logic                   req_valid_i;
    logic [PERF_ADDR_W-1:0] req_addr_i;
    logic                   req_ready_o;
    logic                   rsp_valid_o;
    logic [CNT_WIDTH-1:0]   rsp_data_o;

    modport master (
        output req_valid_i, req_addr_i,
        input  req_ready_o, rsp_valid_o, rsp_data_o
    );

    modport slave (
        input  req_valid_i, req_addr_i,
        output req_ready_o, rsp_valid_o, rsp_data_o
    );
endinterface

// File: rtl/ucsbece154b_bp_perfmon_sat_counter.sv
// One saturating event counter; clear has priority over counting.
module ucsbece154b_sat_counter
    import ucsbece154b_perfmon_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_enable,
    input  logic                 i_clear,
    input  logic [1:0]           i_inc,
    output logic [CNT_WIDTH-1:0] o_count
);
    logic [CNT_WIDTH-1:0] r_count;
    logic [CNT_WIDTH-1:0] w_next;

    assign w_next = CNT_WIDTH'(perf_sat_add(perf_wide_t'(r_count), i_inc, CNT_WIDTH));

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset || i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= w_next;
        end
    end

    assign o_count = r_count;
endmodule

// File: rtl/ucsbece154b_bp_perfmon.sv
// Branch/jump prediction performance monitor with live and shadow counter
// sets and a one-cycle-latency read port.
module ucsbece154b_bp_perfmon
    import ucsbece154b_perfmon_pkg::*;
#(
    parameter int CNT_WIDTH = 32,
    parameter int NUM_SLOTS = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable_i,
    input  logic [NUM_SLOTS-1:0] res_valid_i,
    input  logic [NUM_SLOTS-1:0] res_is_jump_i,
    input  logic [NUM_SLOTS-1:0] res_mispredict_i,
    input  logic                 clear_i,
    input  logic                 snap_i,
    ucsbece154b_bp_perfmon_if.slave rd_bus
);
    perf_inc_t               w_inc;
    logic [1:0]              w_cnt_inc [PERF_NUM_CNT];
    logic [CNT_WIDTH-1:0]    w_live    [PERF_NUM_CNT];
    logic [CNT_WIDTH-1:0]    r_shadow  [PERF_NUM_CNT];
    logic [PERF_IDX_W-1:0]   w_rd_idx;
    logic [CNT_WIDTH-1:0]    w_rd_data;
    logic                    w_accept;
    logic                    r_armed;
    logic                    r_ready;
    logic                    r_rsp_valid;
    logic [CNT_WIDTH-1:0]    r_rsp_data;

    // NOTE: every output of an always_comb gets a default first, so no path can infer a latch.
    always_comb begin
        w_inc = '0;
        for (int k = 0; k < NUM_SLOTS; k++) begin
            if (res_valid_i[k]) begin
                if (res_is_jump_i[k]) begin
                    w_inc.jmp_total = w_inc.jmp_total + 2'd1;
                    if (!res_mispredict_i[k]) w_inc.jmp_correct = w_inc.jmp_correct + 2'd1;
                end else begin
                    w_inc.br_total = w_inc.br_total + 2'd1;
                    if (!res_mispredict_i[k]) w_inc.br_correct = w_inc.br_correct + 2'd1;
                end
            end
        end
    end

    assign w_cnt_inc[PERF_CYCLES]      = 2'd1;
    assign w_cnt_inc[PERF_JMP_TOTAL]   = w_inc.jmp_total;
    assign w_cnt_inc[PERF_JMP_CORRECT] = w_inc.jmp_correct;
    assign w_cnt_inc[PERF_BR_TOTAL]    = w_inc.br_total;
    assign w_cnt_inc[PERF_BR_CORRECT]  = w_inc.br_correct;

    for (genvar g = 0; g < PERF_NUM_CNT; g++) begin : g_cnt
        ucsbece154b_sat_counter #(
            .CNT_WIDTH (CNT_WIDTH)
        ) u_cnt (
            .clk      (clk),
            .reset    (reset),
            .i_enable (enable_i),
            .i_clear  (clear_i),
            .i_inc    (w_cnt_inc[g]),
            .o_count  (w_live[g])
        );
    end

    // NOTE: the shadow set is a small register file that must read 0 after reset, so it is reset explicitly.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < PERF_NUM_CNT; i++) r_shadow[i] <= '0;
        end else if (snap_i) begin
            for (int i = 0; i < PERF_NUM_CNT; i++) r_shadow[i] <= w_live[i];
        end
    end

    assign w_rd_idx = rd_bus.req_addr_i[PERF_IDX_W-1:0];

    always_comb begin
        w_rd_data = '0;
        if (int'(w_rd_idx) < PERF_NUM_CNT) begin
            w_rd_data = rd_bus.req_addr_i[PERF_SHADOW_BIT] ? r_shadow[w_rd_idx] : w_live[w_rd_idx];
        end
    end

    assign w_accept = rd_bus.req_valid_i && r_ready;

    // Ready trails reset release by one full cycle via the armed stage.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_armed     <= 1'b0;
            r_ready     <= 1'b0;
            r_rsp_valid <= 1'b0;
            r_rsp_data  <= '0;
        end else begin
            r_armed     <= 1'b1;
            r_ready     <= r_armed;
            r_rsp_valid <= w_accept;
            if (w_accept) r_rsp_data <= w_rd_data;
        end
    end

    assign rd_bus.req_ready_o = r_ready;
    assign rd_bus.rsp_valid_o = r_rsp_valid;
    assign rd_bus.rsp_data_o  = r_rsp_data;
endmodule

// File: tb/tb_ucsbece154b_bp_perfmon.sv
// Scoreboard bench for the perfmon: a behavioural model queues expected read
// data at acceptance, and the monitor pops it when the response appears.
module tb_ucsbece154b_bp_perfmon;
    localparam int W    = 8;
    localparam int MAXV = 255;

    typedef logic [W-1:0] cnt_arr_t [5];

    logic       clk = 1'b0;
    logic       reset;
    logic       enable;
    logic [1:0] res_valid;
    logic [1:0] res_is_jump;
    logic [1:0] res_mispredict;
    logic       clear;
    logic       snap;

    int n_checks = 0;
    int n_fail   = 0;

    cnt_arr_t   m_live   = '{default: '0};
    cnt_arr_t   m_shadow = '{default: '0};
    logic       exp_valid = 1'b0;
    logic       ready_m   = 1'b0;
    logic       armed_m   = 1'b0;
    logic [W-1:0] sb [$];

    ucsbece154b_bp_perfmon_if #(.CNT_WIDTH(W)) rd_bus ();

    ucsbece154b_bp_perfmon #(
        .CNT_WIDTH (W),
        .NUM_SLOTS (2)
    ) dut (
        .clk              (clk),
        .reset            (reset),
        .enable_i         (enable),
        .res_valid_i      (res_valid),
        .res_is_jump_i    (res_is_jump),
        .res_mispredict_i (res_mispredict),
        .clear_i          (clear),
        .snap_i           (snap),
        .rd_bus           (rd_bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [W-1:0] msat(input logic [W-1:0] v, input int inc);
        int s;
        s = int'(v) + inc;
        return (s > MAXV) ? W'(MAXV) : W'(s);
    endfunction

    function automatic logic [W-1:0] model_read(input logic [3:0] addr);
        if (addr[2:0] > 3'd4) return '0;
        return addr[3] ? m_shadow[addr[2:0]] : m_live[addr[2:0]];
    endfunction

    // Reference model, evaluated on the same edge the DUT samples its inputs.
    always @(posedge clk) begin : model
        cnt_arr_t nl;
        int jt, jc, bt, bc;
        logic acc;
        if (reset) begin
            m_live    <= '{default: '0};
            m_shadow  <= '{default: '0};
            exp_valid <= 1'b0;
            ready_m   <= 1'b0;
            armed_m   <= 1'b0;
            sb.delete();
        end else begin
            acc = rd_bus.req_valid_i && ready_m;
            if (acc) sb.push_back(model_read(rd_bus.req_addr_i));
            exp_valid <= acc;
            armed_m   <= 1'b1;
            ready_m   <= armed_m;
            if (snap) m_shadow <= m_live;
            nl = m_live;
            if (clear) begin
                nl = '{default: '0};
            end else if (enable) begin
                jt = 0; jc = 0; bt = 0; bc = 0;
                for (int k = 0; k < 2; k++) begin
                    if (res_valid[k] && res_is_jump[k]) begin
                        jt++;
                        if (!res_mispredict[k]) jc++;
                    end else if (res_valid[k]) begin
                        bt++;
                        if (!res_mispredict[k]) bc++;
                    end
                end
                nl[0] = msat(nl[0], 1);
                nl[1] = msat(nl[1], jt);
                nl[2] = msat(nl[2], jc);
                nl[3] = msat(nl[3], bt);
                nl[4] = msat(nl[4], bc);
            end
            m_live <= nl;
        end
    end

    // Output monitor, sampled mid-cycle.
    always @(negedge clk) begin
        check("req_ready", 32'(rd_bus.req_ready_o), 32'(ready_m));
        check("rsp_valid", 32'(rd_bus.rsp_valid_o), 32'(exp_valid));
        if (exp_valid) begin
            check("sb_depth", 32'(sb.size()), 32'd1);
            if (sb.size() != 0) check("rsp_data", 32'(rd_bus.rsp_data_o), 32'(sb.pop_front()));
        end
    end

    task automatic rd(input logic [3:0] addr, input logic [W-1:0] exp, input string tag);
        rd_bus.req_valid_i = 1'b1;
        rd_bus.req_addr_i  = addr;
        @(negedge clk);
        rd_bus.req_valid_i = 1'b0;
        check(tag, 32'(rd_bus.rsp_data_o), 32'(exp));
    endtask

    task automatic set_res(input logic [1:0] v, input logic [1:0] j, input logic [1:0] m);
        res_valid      = v;
        res_is_jump    = j;
        res_mispredict = m;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; enable = 1'b0; clear = 1'b0; snap = 1'b0;
        set_res(2'b00, 2'b00, 2'b00);
        rd_bus.req_valid_i = 1'b0;
        rd_bus.req_addr_i  = '0;
        repeat (2) @(negedge clk);
        check("rst_ready", 32'(rd_bus.req_ready_o), 32'd0);
        check("rst_rsp_valid", 32'(rd_bus.rsp_valid_o), 32'd0);
        check("rst_rsp_data", 32'(rd_bus.rsp_data_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);

        // Idle counting: only the cycle counter moves.
        enable = 1'b1;
        repeat (10) @(negedge clk);
        enable = 1'b0;
        rd(4'd0, 8'd10, "cycles_10");
        rd(4'd1, 8'd0, "jt_idle");
        rd(4'd2, 8'd0, "jc_idle");
        rd(4'd3, 8'd0, "bt_idle");
        rd(4'd4, 8'd0, "bc_idle");
        rd(4'd6, 8'd0, "idx6_zero");
        rd(4'd8, 8'd0, "shadow_idle");

        // Two jumps in one cycle, slot1 mispredicted.
        set_res(2'b11, 2'b11, 2'b10);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        set_res(2'b00, 2'b00, 2'b00);
        rd(4'd1, 8'd2, "jt_two");
        rd(4'd2, 8'd1, "jc_one");
        rd(4'd3, 8'd0, "bt_after_jmp");
        rd(4'd4, 8'd0, "bc_after_jmp");

        // Dual correct branches, then frozen while disabled.
        set_res(2'b11, 2'b00, 2'b00);
        enable = 1'b1;
        repeat (5) @(negedge clk);
        enable = 1'b0;
        repeat (3) @(negedge clk);
        rd(4'd3, 8'd10, "bt_10");
        rd(4'd4, 8'd10, "bc_10");

        // Invalid slot bits are ignored.
        set_res(2'b01, 2'b10, 2'b10);
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        rd(4'd3, 8'd11, "bt_ign");
        rd(4'd1, 8'd2, "jt_ign");

        // Saturation: 254 + 2 lands on 255 and stays there.
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        set_res(2'b11, 2'b00, 2'b00);
        enable = 1'b1;
        repeat (127) @(negedge clk);
        enable = 1'b0;
        rd(4'd3, 8'd254, "bt_254");
        enable = 1'b1;
        @(negedge clk);
        enable = 1'b0;
        rd(4'd3, 8'd255, "bt_sat");
        rd(4'd4, 8'd255, "bc_sat");
        enable = 1'b1;
        repeat (3) @(negedge clk);
        enable = 1'b0;
        rd(4'd3, 8'd255, "bt_hold");
        rd(4'd1, 8'd0, "jt_cleared");

        // Snap + clear + read together.
        set_res(2'b00, 2'b00, 2'b00);
        clear = 1'b1;
        @(negedge clk);
        clear = 1'b0;
        enable = 1'b1;
        repeat (20) @(negedge clk);
        rd_bus.req_valid_i = 1'b1;
        rd_bus.req_addr_i  = 4'd0;
        snap = 1'b1; clear = 1'b1;
        @(negedge clk);
        snap = 1'b0; clear = 1'b0;
        rd_bus.req_valid_i = 1'b0;
        check("snap_rd", 32'(rd_bus.rsp_data_o), 32'd20);
        rd(4'd8, 8'd20, "shadow_20");
        rd(4'd0, 8'd1, "live_after_clr");
        enable = 1'b0;

        // Request and reset in the same cycle: no response.
        rd_bus.req_valid_i = 1'b1;
        rd_bus.req_addr_i  = 4'd0;
        reset = 1'b1;
        @(negedge clk);
        rd_bus.req_valid_i = 1'b0;
        check("rst_drop", 32'(rd_bus.rsp_valid_o), 32'd0);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        check("rdy_post0", 32'(rd_bus.req_ready_o), 32'd0);
        @(negedge clk);
        check("rdy_post1", 32'(rd_bus.req_ready_o), 32'd1);
        rd(4'd0, 8'd0, "cycles_after_rst");

        // Accepted read, reset on the following cycle.
        rd_bus.req_valid_i = 1'b1;
        rd_bus.req_addr_i  = 4'd8;
        @(negedge clk);
        rd_bus.req_valid_i = 1'b0;
        reset = 1'b1;
        check("rsp_b", 32'(rd_bus.rsp_valid_o), 32'd1);
        @(negedge clk);
        check("rsp_b_gone", 32'(rd_bus.rsp_valid_o), 32'd0);
        check("rst_rsp_data2", 32'(rd_bus.rsp_data_o), 32'd0);
        reset = 1'b0;
        @(negedge clk);
        check("rdy_b0", 32'(rd_bus.req_ready_o), 32'd0);
        @(negedge clk);
        check("rdy_b1", 32'(rd_bus.req_ready_o), 32'd1);

        check("sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/ucsbece154b_bp_perfmon.md
Name: ucsbece154b_bp_perfmon

Overview:
- Branch/jump prediction performance monitor inside the superscalar core, fed by the two execute-stage resolution slots.
- Counts cycles, jumps and branches, and how many of each were predicted correctly.
- A request/response read port lets a bench or debug master sample the counters without hierarchical peeking.
- Supports atomic snapshot and clear.

Parameters:
CNT_WIDTH, 32, width of every counter; all counters saturate at 2^CNT_WIDTH-1
NUM_SLOTS, 2, resolution slots per cycle; this revision supports only 2

Ports:
clk  in  1  rising-edge clock
reset  in  1  synchronous, active-high reset
enable_i  in  1  counting enabled (core not halted)
res_valid_i  in  2  slot k resolved a control-flow instruction this cycle
res_is_jump_i  in  2  slot k is jal/jalr (1) or conditional branch (0)
res_mispredict_i  in  2  slot k prediction was wrong (target or direction)
clear_i  in  1  zero all live counters
snap_i  in  1  copy live counters into the shadow set
req_valid_i  in  1  read request
req_addr_i  in  4  bit3 = shadow select; bits2:0 = counter index
req_ready_o  out  1  request accepted this cycle
rsp_valid_o  out  1  read data valid
rsp_data_o  out  CNT_WIDTH  read data

Behaviour:
- Counter index: 0 cycles, 1 jump_total, 2 jump_correct, 3 branch_total, 4 branch_correct; indices 5-7 read 0.
- Reset: all live and shadow counters 0; rsp_valid_o 0; rsp_data_o 0; req_ready_o 0. req_ready_o stays 0 during the first cycle after reset deasserts and is 1 from the next cycle.
- Update, only when enable_i=1:
  - cycles +1 each cycle.
  - Per valid slot: jump_total or branch_total +1; the matching *_correct counter +1 when mispredict=0.
  - Both slots may hit the same counter in one cycle: increment by 2.
  - Compute the sum at CNT_WIDTH+1 bits; clamp to max if it overflows, so a counter at max-1 plus 2 lands on max.
- res_* bits for slots with res_valid_i=0 are ignored.
- clear_i: the next-state of every live counter is 0, and events in the clear cycle are dropped (clear wins over update). Shadow counters are unaffected.
- snap_i: the shadow set takes the live values as they are at the start of the cycle, i.e. before this cycle's updates.
- snap_i and clear_i in the same cycle: the shadow gets the pre-clear values and the live set goes to 0.
- Read handshake:
  - A request is accepted when req_valid_i && req_ready_o.
  - rsp_valid_o=1 exactly one cycle after acceptance, with rsp_data_o = the register value at the acceptance cycle (pre-update).
  - Back-to-back reads are allowed at 1 per cycle.
  - rsp_valid_o is a single-cycle pulse per request; rsp_data_o holds its last value otherwise.
- Read, clear and snap in the same cycle: the response returns the pre-clear, pre-snap value.
- Reset asserted mid-read: the pending response is dropped (rsp_valid_o=0 the next cycle).
- enable_i=0 freezes all counting; reads, clear and snap still operate.

Decomposition:
- Package ucsbece154b_perfmon_pkg holds:
  - counter index localparams (PERF_CYCLES=0 … PERF_BR_CORRECT=4) and PERF_SHADOW_BIT=3;
  - a function that returns the saturating add of a 0..2 increment.
- One sub-module: ucsbece154b_sat_counter, a single CNT_WIDTH saturating counter with inc amount (0..2), clear and enable. It is instantiated 5 times. The shadow set and the read mux live in the top.

Test Plan:
- Reset 2 cycles, enable 10 cycles with no resolutions, read addr 0 → rsp one cycle later = 10; all other indices read 0; index 6 reads 0.
- Slot0 jump correct + slot1 jump mispredicted in one cycle → jump_total=2, jump_correct=1, branch counters 0.
- Both slots correct branches for 5 cycles → branch_total=10, branch_correct=10. Then enable_i=0 for 3 cycles with valid events → counts unchanged.
- Force branch_total to max-1 (CNT_WIDTH=8: 254), then apply two branches → 255. Further events keep it at 255.
- After 20 enabled cycles: assert snap_i, clear_i and a read of addr 0 together → rsp = 20; shadow read (addr 8) = 20; live read of addr 0 two cycles later = 1.
- Read request accepted, reset asserted the next cycle → rsp_valid_o=0; after release, req_ready_o=0 for 1 cycle, then 1.
